// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode encodings, request bundle
// and the opcode-legality helper used by the arbiter and the ALU.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b01010,
        OP_AND  = 5'b00111,
        OP_OR   = 5'b00110,
        OP_XOR  = 5'b00100,
        OP_SLT  = 5'b01100,
        OP_SLTU = 5'b01110,
        OP_SLL  = 5'b00001,
        OP_SRL  = 5'b00101,
        OP_SRA  = 5'b01011
    } alu_op_e;

    // Operands and opcode presented to the shared ALU.
    typedef struct packed {
        logic [4:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_req_t;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
            default:                                 op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Unknown opcodes give 0.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  alu_req_t        req,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    // Opcode decode; shifts use only the low five bits of b.
    always_comb begin
        result = '0;
        case (req.op)
            OP_ADD:  result = req.a + req.b;
            OP_SUB:  result = req.a - req.b;
            OP_AND:  result = req.a & req.b;
            OP_OR:   result = req.a | req.b;
            OP_XOR:  result = req.a ^ req.b;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, $signed(req.a) < $signed(req.b)};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, req.a < req.b};
            OP_SLL:  result = req.a << req.b[4:0];
            OP_SRL:  result = req.a >> req.b[4:0];
            OP_SRA:  result = $unsigned($signed(req.a) >>> req.b[4:0]);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU. One request is
// accepted per cycle; each requester gets its own registered response slot.
// Optional feature: define ALU_ARB_ILLEGAL_OP_EN to add rsp_err, a
// registered per-requester flag for opcodes outside the legal set.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_INIT = 0,
    parameter int XLEN    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    input  logic [9:0]        req_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [2*XLEN-1:0] rsp_result,
    output logic [1:0]        rsp_zero
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    output logic [1:0]        rsp_err
`endif
);

    localparam int NREQ = 2;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic            prio;      // requester holding first priority on a tie
    alu_req_t        alu_in;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;

    // A slot can take a new request if empty or being drained this cycle.
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    // Grant: lone eligible requester wins outright, ties go to prio.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            case (elig)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = '0;
            endcase
        end
    end

    assign req_ready = gnt;

    // Priority passes to the other requester after every grant.
    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'(RR_INIT);
        else if (|gnt)
            prio <= gnt[0];
    end

    // Operand mux; idle cycles present zeros to the ALU.
    always_comb begin
        alu_in = '0;
        if (gnt[1])
            alu_in = '{op: req_op[5 +: 5], a: req_a[XLEN +: XLEN], b: req_b[XLEN +: XLEN]};
        else if (gnt[0])
            alu_in = '{op: req_op[0 +: 5], a: req_a[0 +: XLEN], b: req_b[0 +: XLEN]};
    end

    alu_arbiter_alu u_alu (
        .req    (alu_in),
        .result (alu_res),
        .zero   (alu_zero)
    );

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        logic            vld_q;
        logic [XLEN-1:0] res_q;
        logic            zero_q;

        // Load on grant (also back-to-back), clear once consumed, else hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                res_q  <= '0;
                zero_q <= 1'b0;
            end else if (gnt[i]) begin
                vld_q  <= 1'b1;
                res_q  <= alu_res;
                zero_q <= alu_zero;
            end else if (vld_q && rsp_ready[i]) begin
                vld_q  <= 1'b0;
            end
        end

        assign rsp_valid[i]               = vld_q;
        assign rsp_result[i*XLEN +: XLEN] = res_q;
        assign rsp_zero[i]                = zero_q;

`ifdef ALU_ARB_ILLEGAL_OP_EN
        logic err_q;

        // Illegal-opcode flag travels with the response it belongs to.
        always_ff @(posedge clk) begin
            if (rst)
                err_q <= 1'b0;
            else if (gnt[i])
                err_q <= ~op_legal(alu_in.op);
        end

        assign rsp_err[i] = err_q;
`endif
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int RR_INIT = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero;
    logic [63:0] req_a, req_b, rsp_result;
    logic [9:0]  req_op;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic [1:0]  rsp_err;
`endif

    alu_arbiter #(.RR_INIT(RR_INIT), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_ILLEGAL_OP_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: one response slot per requester plus priority.
    logic [1:0]  m_vld   = '0;
    logic [31:0] m_res [2];
    logic        m_zero[2];
    logic        m_err [2];
    logic        m_known[2];
    logic        m_prio  = 1'(RR_INIT);
    logic [1:0]  last_g  = '0;

    logic [4:0] ops [10] = '{5'b00000, 5'b01010, 5'b00111, 5'b00110, 5'b00100,
                             5'b01100, 5'b01110, 5'b00001, 5'b00101, 5'b01011};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            5'b00000: return a + b;
            5'b01010: return a - b;
            5'b00111: return a & b;
            5'b00110: return a | b;
            5'b00100: return a ^ b;
            5'b01100: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'b01110: return (a < b) ? 32'd1 : 32'd0;
            5'b00001: return a << sh;
            5'b00101: return a >> sh;
            5'b01011: return 32'($signed(a) >>> sh);
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [4:0] op);
        foreach (ops[k]) if (ops[k] == op) return 1'b0;
        return 1'b1;
    endfunction

    // Spec-level grant: who may take a request, ties broken by priority.
    function automatic logic [1:0] ref_grant();
        logic [1:0] e;
        if (rst) return 2'b00;
        e = req_valid & (~m_vld | rsp_ready);
        if (e == 2'b11) return m_prio ? 2'b10 : 2'b01;
        return e;
    endfunction

    // One clock: check ready, advance model at the edge, check responses.
    task automatic cycle();
        logic [1:0] g;
        g = ref_grant();
        #1 chk("req_ready", req_ready, g);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_vld[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b0; m_err[i] = 1'b0; m_known[i] = 1'b1;
            end else if (g[i]) begin
                m_vld[i]   = 1'b1;
                m_res[i]   = ref_alu(req_op[i*5 +: 5], req_a[i*32 +: 32], req_b[i*32 +: 32]);
                m_zero[i]  = (m_res[i] == 0);
                m_err[i]   = ref_illegal(req_op[i*5 +: 5]);
                m_known[i] = 1'b1;
            end else if (m_vld[i] && rsp_ready[i]) begin
                m_vld[i]   = 1'b0;
                m_known[i] = 1'b0;
            end
        end
        if (rst) m_prio = 1'(RR_INIT);
        else if (g != 0) m_prio = (g == 2'b01);
        last_g = g;
        #1;
        chk("rsp_valid", rsp_valid, m_vld);
        for (int i = 0; i < 2; i++) begin
            if (m_known[i]) begin
                chk($sformatf("rsp_result%0d", i), rsp_result[i*32 +: 32], m_res[i]);
                chk($sformatf("rsp_zero%0d", i), rsp_zero[i], m_zero[i]);
`ifdef ALU_ARB_ILLEGAL_OP_EN
                chk($sformatf("rsp_err%0d", i), rsp_err[i], m_err[i]);
`endif
            end
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[i*5 +: 5] = op;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] hold;
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        foreach (m_known[i]) begin m_known[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b0; m_err[i] = 1'b0; end

        // Reset then idle
        do_reset();
        chk("rst_result", rsp_result, 64'd0);
        chk("rst_zero", rsp_zero, 2'b00);
        cycle();
        chk("idle_valid", rsp_valid, 2'b00);

        // Single request: ADD 5+7
        set_req(0, 5'b00000, 32'd5, 32'd7); req_valid = 2'b01;
        #1 chk("add_ready", req_ready, 2'b01);
        cycle();
        req_valid = 2'b00;
        chk("add_valid", rsp_valid, 2'b01);
        chk("add_res", rsp_result[31:0], 32'd12);
        chk("add_zero", rsp_zero[0], 1'b0);
        rsp_ready = 2'b11; cycle();

        // Contention: alternating grants starting at requester 0
        do_reset();
        set_req(0, 5'b01010, 32'd3, 32'd3);
        set_req(1, 5'b01011, 32'h8000_0000, 32'd4);
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            cycle();
            if (k == 0) begin
                chk("sub_res", rsp_result[31:0], 32'd0);
                chk("sub_zero", rsp_zero[0], 1'b1);
            end
            if (k == 1) chk("sra_res", rsp_result[63:32], 32'hF800_0000);
        end
        req_valid = 2'b00; cycle();

        // Backpressure on requester 1
        do_reset();
        rsp_ready = 2'b00;
        set_req(1, 5'b00000, 32'd1, 32'd1); req_valid = 2'b10;
        cycle();
        set_req(1, 5'b00000, 32'd2, 32'd2);
        for (int k = 0; k < 2; k++) begin
            #1 chk("bp_stall", req_ready, 2'b00);
            cycle();
            chk("bp_hold", rsp_result[63:32], 32'd2);
        end
        rsp_ready = 2'b10;
        #1 chk("bp_go", req_ready, 2'b10);
        cycle();
        chk("bp_b2b_valid", rsp_valid[1], 1'b1);
        chk("bp_b2b_res", rsp_result[63:32], 32'd4);
        req_valid = 2'b00; cycle();
        chk("bp_drain", rsp_valid, 2'b00);

        // Mid-operation reset, then illegal opcode
        set_req(0, 5'b00000, 32'd1, 32'd2); req_valid = 2'b01; rsp_ready = 2'b00;
        cycle();
        rst = 1'b1; req_valid = 2'b11;
        #1 chk("rst_noaccept", req_ready, 2'b00);
        cycle();
        chk("rst_discard", rsp_valid, 2'b00);
        rst = 1'b0; req_valid = 2'b00;
        cycle();
        chk("rst_nostale", rsp_valid, 2'b00);
        set_req(0, 5'b11111, 32'd5, 32'd6); req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        chk("ill_res", rsp_result[31:0], 32'd0);
        chk("ill_zero", rsp_zero[0], 1'b1);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("ill_err", rsp_err[0], 1'b1);
`endif
        rsp_ready = 2'b11; cycle();

        // Randomized traffic; pending requests keep their payload.
        for (int n = 0; n < 800; n++) begin
            hold = req_valid & ~last_g;
            rst  = ($urandom_range(99) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    req_valid[i] = ($urandom_range(3) != 0);
                    set_req(i, ($urandom_range(7) == 0) ? 5'($urandom) : ops[$urandom_range(9)],
                            $urandom, ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom);
                end
            end
            rsp_ready = 2'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
